// File: rtl/pb_seq_conditioner.sv
// Push-button conditioner for the sequencer: synchronises and debounces two
// raw active-low keys, adds optional auto-repeat, and arbitrates colliding pulses.

module pb_seq_btn #(
    parameter int unsigned DB_CYCLES     = 16,
    parameter int unsigned REPEAT_DELAY  = 0,
    parameter int unsigned REPEAT_PERIOD = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_fire,
    output logic o_held
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    localparam logic [15:0] DB_M1  = 16'(DB_CYCLES - 1);
    localparam logic [15:0] RD16   = 16'(REPEAT_DELAY);
    localparam logic [15:0] RP16   = 16'(REPEAT_PERIOD);
    localparam bit          DB_ONE = (DB_CYCLES <= 1);

    state_t      r_state, w_state_nx;
    logic [1:0]  r_sync;
    logic [15:0] r_cnt, w_cnt_nx, w_cnt_inc;
    logic [15:0] r_rcnt, w_rcnt_nx, w_rcnt_inc;
    logic        r_rep_on, w_rep_on_nx;
    logic        r_held;
    logic        w_lvl;

    // Sync flops reset to the released level so reset never looks like a press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sync <= 2'b11;
        else          r_sync <= {r_sync[0], i_key_n};
    end

    assign w_lvl      = ~r_sync[1];
    assign w_cnt_inc  = (r_cnt  == 16'hFFFF) ? r_cnt  : r_cnt  + 16'd1;
    assign w_rcnt_inc = (r_rcnt == 16'hFFFF) ? r_rcnt : r_rcnt + 16'd1;

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_rcnt_nx   = r_rcnt;
        w_rep_on_nx = r_rep_on;
        o_fire      = 1'b0;
        case (r_state)
            IDLE: begin
                w_rcnt_nx   = '0;
                w_rep_on_nx = 1'b0;
                w_cnt_nx    = '0;
                if (w_lvl) begin
                    if (DB_ONE) begin
                        w_state_nx = HELD;
                        o_fire     = 1'b1;
                    end else begin
                        w_state_nx = PRESS_WAIT;
                        w_cnt_nx   = 16'd1;
                    end
                end
            end
            PRESS_WAIT: begin
                if (!w_lvl) begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                end else if (r_cnt >= DB_M1) begin
                    w_state_nx  = HELD;
                    w_cnt_nx    = '0;
                    w_rcnt_nx   = '0;
                    w_rep_on_nx = 1'b0;
                    o_fire      = 1'b1;
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
            HELD: begin
                if (!w_lvl) begin
                    if (DB_ONE) begin
                        w_state_nx = IDLE;
                        w_cnt_nx   = '0;
                    end else begin
                        w_state_nx = RELEASE_WAIT;
                        w_cnt_nx   = 16'd1;
                    end
                end else if (REPEAT_DELAY > 0) begin
                    // Count to the first delay, then reload against the period.
                    if (w_rcnt_inc == (r_rep_on ? RP16 : RD16)) begin
                        o_fire      = 1'b1;
                        w_rcnt_nx   = '0;
                        w_rep_on_nx = 1'b1;
                    end else begin
                        w_rcnt_nx = w_rcnt_inc;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (w_lvl) begin
                    w_state_nx = HELD;
                    w_cnt_nx   = '0;
                end else if (r_cnt >= DB_M1) begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_rcnt   <= '0;
            r_rep_on <= 1'b0;
            r_held   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_rcnt   <= w_rcnt_nx;
            r_rep_on <= w_rep_on_nx;
            r_held   <= (w_state_nx == HELD) || (w_state_nx == RELEASE_WAIT);
        end
    end

    assign o_held = r_held;
endmodule

module pb_seq_conditioner #(
    parameter int unsigned DB_CYCLES     = 16,
    parameter int unsigned REPEAT_DELAY  = 0,
    parameter int unsigned REPEAT_PERIOD = 8
) (
    input  logic clock_n,
    input  logic reset,
    input  logic key_up_n,
    input  logic key_dn_n,
    output logic pb_seq_up,
    output logic pb_seq_dn,
    output logic pb_conflict,
    output logic up_held,
    output logic dn_held
);
    localparam int NUM_BTN = 2;

    logic [NUM_BTN-1:0] w_key_n, w_fire, w_held;
    logic               r_up, r_dn, r_conf;

    assign w_key_n = {key_dn_n, key_up_n};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        pb_seq_btn #(
            .DB_CYCLES    (DB_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_btn (
            .i_clk  (clock_n),
            .i_rst_n(reset),
            .i_key_n(w_key_n[g]),
            .o_fire (w_fire[g]),
            .o_held (w_held[g])
        );
    end

    // Masking with the previous output keeps every pulse output one cycle wide.
    always_ff @(posedge clock_n or negedge reset) begin
        if (!reset) begin
            r_up   <= 1'b0;
            r_dn   <= 1'b0;
            r_conf <= 1'b0;
        end else begin
            r_up   <= w_fire[0] & ~w_fire[1] & ~r_up;
            r_dn   <= w_fire[1] & ~w_fire[0] & ~r_dn;
            r_conf <= w_fire[0] &  w_fire[1] & ~r_conf;
        end
    end

    assign pb_seq_up   = r_up;
    assign pb_seq_dn   = r_dn;
    assign pb_conflict = r_conf;
    assign up_held     = w_held[0];
    assign dn_held     = w_held[1];
endmodule

// File: tb/tb_pb_seq_conditioner.sv
// Scoreboarded bench for pb_seq_conditioner: two instances (no repeat / repeat
// 10,5), a run-length reference model, and a monitor comparing pulses and held levels.

module tb_pb_seq_conditioner;
    localparam int DB  = 4;
    localparam int RD0 = 0;
    localparam int RP0 = 8;
    localparam int RD1 = 10;
    localparam int RP1 = 5;

    typedef struct { int cyc; int inst; logic [2:0] code; } pev_t;
    typedef struct { int cyc; int inst; logic [1:0] held; } hev_t;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       key_up_n = 1'b1;
    logic       key_dn_n = 1'b1;
    logic [1:0] up, dn, conf, uh, dh;

    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    pev_t pq[$];
    hev_t hq[$];
    event chk_ev;
    bit   chk_rst = 1'b0;

    // Reference model state: raw samples delayed two edges, run lengths of the
    // delayed level, debounced level, and repeat tally since acceptance.
    int         mrd[2] = '{RD0, RD1};
    int         mrp[2] = '{RP0, RP1};
    bit         d1[2][2], d2[2][2], deb[2][2], plv[2][2];
    int         run1[2][2], run0[2][2], tc[2][2];
    logic [2:0] pout[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pb_seq_conditioner #(.DB_CYCLES(DB), .REPEAT_DELAY(RD0), .REPEAT_PERIOD(RP0)) u_dut0 (
        .clock_n(clk), .reset(rst_n), .key_up_n(key_up_n), .key_dn_n(key_dn_n),
        .pb_seq_up(up[0]), .pb_seq_dn(dn[0]), .pb_conflict(conf[0]),
        .up_held(uh[0]), .dn_held(dh[0]));

    pb_seq_conditioner #(.DB_CYCLES(DB), .REPEAT_DELAY(RD1), .REPEAT_PERIOD(RP1)) u_dut1 (
        .clock_n(clk), .reset(rst_n), .key_up_n(key_up_n), .key_dn_n(key_dn_n),
        .pb_seq_up(up[1]), .pb_seq_dn(dn[1]), .pb_conflict(conf[1]),
        .up_held(uh[1]), .dn_held(dh[1]));

    // Predict outputs after the coming rising edge from the pressed samples
    // taken on that edge.
    task automatic model_edge(input bit rok, input bit pu, input bit pd);
        int         n;
        bit         f[2];
        bit         r, lv;
        logic [2:0] code;
        n = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < 2; b++) begin
                r    = (b == 0) ? pu : pd;
                f[b] = 1'b0;
                if (!rok) begin
                    d1[i][b] = 0; d2[i][b] = 0; deb[i][b] = 0; plv[i][b] = 0;
                    run1[i][b] = 0; run0[i][b] = 0; tc[i][b] = 0;
                end else begin
                    lv = d2[i][b];
                    d2[i][b] = d1[i][b];
                    d1[i][b] = r;
                    if (lv) begin run1[i][b]++; run0[i][b] = 0; end
                    else    begin run0[i][b]++; run1[i][b] = 0; end
                    if (!deb[i][b] && run1[i][b] >= DB) begin
                        deb[i][b] = 1; f[b] = 1; tc[i][b] = 0;
                    end else if (deb[i][b] && run0[i][b] >= DB) begin
                        deb[i][b] = 0;
                    end else if (deb[i][b] && lv && plv[i][b] && mrd[i] > 0) begin
                        tc[i][b]++;
                        if (tc[i][b] == mrd[i] ||
                            (tc[i][b] > mrd[i] && (tc[i][b] - mrd[i]) % mrp[i] == 0))
                            f[b] = 1;
                    end
                    plv[i][b] = lv;
                end
            end
            code[2] = f[0] & f[1] & ~pout[i][2];
            code[1] = f[1] & ~f[0] & ~pout[i][1];
            code[0] = f[0] & ~f[1] & ~pout[i][0];
            if (!rok) code = 3'b000;
            pout[i] = code;
            if (code != 3'b000) pq.push_back(pev_t'{n, i, code});
            hq.push_back(hev_t'{n, i, {deb[i][1], deb[i][0]}});
        end
    endtask

    task automatic step(input bit upn, input bit dnn, input bit rok);
        @(negedge clk);
        #1;
        key_up_n = upn;
        key_dn_n = dnn;
        rst_n    = rok;
        model_edge(rok, ~upn, ~dnn);
    endtask

    task automatic hold(input bit upn, input bit dnn, input int n);
        repeat (n) step(upn, dnn, 1'b1);
    endtask

    // Reset lands mid-cycle; outputs must drop before the next clock edge.
    task automatic step_mid_reset(input bit upn, input bit dnn);
        @(negedge clk);
        #1;
        key_up_n = upn;
        key_dn_n = dnn;
        model_edge(1'b0, ~upn, ~dnn);
        #2 rst_n = 1'b0;
        #1 chk_rst = 1'b1;
        -> chk_ev;
        #1 chk_rst = 1'b0;
    endtask

    initial begin : monitor
        logic [2:0] ec[2];
        logic [1:0] eh[2];
        bit         hv[2];
        logic [2:0] act;
        logic [1:0] ah;
        pev_t       pe;
        hev_t       he;
        forever begin
            @(negedge clk or chk_ev);
            if (chk_rst) begin
                for (int i = 0; i < 2; i++) begin
                    n_cmp++;
                    if ({conf[i], dn[i], up[i], dh[i], uh[i]} != 5'b0) begin
                        n_bad++;
                        $display("FAIL async_reset dut%0d: outputs %b, required 00000",
                                 i, {conf[i], dn[i], up[i], dh[i], uh[i]});
                    end
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    ec[i] = 3'b000; eh[i] = 2'b00; hv[i] = 1'b0;
                end
                while (pq.size() > 0 && pq[0].cyc <= cyc) begin
                    pe = pq.pop_front();
                    ec[pe.inst] = pe.code;
                end
                while (hq.size() > 0 && hq[0].cyc <= cyc) begin
                    he = hq.pop_front();
                    eh[he.inst] = he.held;
                    hv[he.inst] = 1'b1;
                end
                for (int i = 0; i < 2; i++) begin
                    act = {conf[i], dn[i], up[i]};
                    if (act != 3'b000 || ec[i] != 3'b000) begin
                        n_cmp++;
                        if (act != ec[i]) begin
                            n_bad++;
                            $display("FAIL pulse dut%0d cyc %0d: {conf,dn,up}=%b, required %b",
                                     i, cyc, act, ec[i]);
                        end
                    end
                    if (hv[i]) begin
                        ah = {dh[i], uh[i]};
                        n_cmp++;
                        if (ah != eh[i]) begin
                            n_bad++;
                            $display("FAIL held dut%0d cyc %0d: {dn,up}_held=%b, required %b",
                                     i, cyc, ah, eh[i]);
                        end
                    end
                end
            end
        end
    end

    initial begin : stim
        bit u, d;
        int pf;
        u  = 1'b1;
        d  = 1'b1;
        pf = 8;
        repeat (3) step(1, 1, 0);
        hold(1, 1, 4);
        // clean up press then release
        hold(0, 1, 20); hold(1, 1, 12);
        // bouncing down key, then stable
        repeat (3) begin hold(1, 0, 3); hold(1, 1, 2); end
        hold(1, 0, 12); hold(1, 1, 12);
        // simultaneous press, then a lone up press
        hold(0, 0, 8); hold(1, 1, 10); hold(0, 1, 10); hold(1, 1, 10);
        // long hold for auto-repeat
        hold(0, 1, 40); hold(1, 1, 12);
        // reset while the press is still being debounced
        hold(0, 1, 3); step_mid_reset(0, 1); repeat (2) step(0, 1, 0);
        hold(0, 1, 12); hold(1, 1, 12);
        // reset while held
        hold(1, 0, 10); step_mid_reset(1, 0); repeat (2) step(1, 1, 0);
        hold(1, 1, 6);
        // single-cycle release glitch while held
        hold(0, 1, 10); hold(1, 1, 1); hold(0, 1, 10); hold(1, 1, 12);
        // up press while down is held
        hold(1, 0, 10); hold(0, 0, 10); hold(1, 0, 5); hold(1, 1, 12);
        // randomized bouncing with occasional one-cycle resets
        for (int k = 0; k < 800; k++) begin
            if (k % 100 == 0) pf = $urandom_range(2, 24);
            if ($urandom_range(1, pf) == 1) u = ~u;
            if ($urandom_range(1, pf) == 1) d = ~d;
            step(u, d, $urandom_range(0, 299) != 0);
        end
        hold(1, 1, 12);
        @(negedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
